commit_map_quad: RTL and testbench

//  Commit-side counterpart of the quad free list: holds the committed arch->phys map and turns each

---
 rtl/fl_pkg.sv | 16 +
 rtl/commit_map_quad_free_tag_select.sv | 34 +++
 rtl/commit_map_quad.sv | 121 ++++++++++++
 tb/tb_commit_map_quad.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fl_pkg.sv
// Shared constants and types for the quad free list and its commit-side map.
//   WIDTH      : slots per rename/commit group (port lists are unrolled for 4)
//   N_ARCH     : architectural registers; reset map is arch r -> phys r
//   TAG_BITS   : physical tag width
//   STACK_SIZE : free-list depth; the committed front wraps modulo this
package fl_pkg;

  localparam int WIDTH      = 4;
  localparam int N_ARCH     = 32;
  localparam int TAG_BITS   = 6;
  localparam int STACK_SIZE = 64;

  typedef logic [TAG_BITS-1:0] phys_tag_t;
  typedef logic [4:0]          arch_reg_t;

endpackage

// File: rtl/commit_map_quad_free_tag_select.sv
// free_tag_select: picks the tag that one slot of a committing group hands back
// to the free list.
//   destValid : per-slot "writes an arch register" flags (bit i = slot i, slot 0 oldest)
//   archDest  : per-slot arch destination
//   physNew   : per-slot phys tag taken at rename
//   mapValue  : committed map entry for archDest[SLOT] before this group
//   freeTag   : tag released by slot SLOT
// Purely combinational.
module free_tag_select
  import fl_pkg::*;
#(
  parameter int SLOT = WIDTH - 1
) (
  input  logic      [WIDTH-1:0] destValid,
  input  arch_reg_t [WIDTH-1:0] archDest,
  input  phys_tag_t [WIDTH-1:0] physNew,
  input  phys_tag_t             mapValue,
  output phys_tag_t             freeTag
);

  always_comb begin
    // A slot with no destination returns its own unused take; a writing slot
    // frees whatever the register mapped to just before it.
    freeTag = destValid[SLOT] ? mapValue : physNew[SLOT];
    // Scan older slots upward so the youngest older writer of the same arch
    // register overrides the pre-group map value.
    for (int k = 0; k < SLOT; k++) begin
      if (destValid[SLOT] && destValid[k] && (archDest[k] == archDest[SLOT])) begin
        freeTag = physNew[k];
      end
    end
  end

endmodule

// File: rtl/commit_map_quad.sv
// commit_map_quad: committed arch->phys map plus committed free-list front.
// Turns each committed rename group into four tag returns for the free list
// and supplies the rewind position on a flush.
//   clk, reset (sync, active low), en (global enable, state holds when 0)
//   group_commit, dest_valid[3:0] (bit i = slot i), arch_dest0..3, phys_new0..3,
//   rewind_req                                     : commit-stage inputs
//   put[3:0], enable_put, free_tag0..3             : free-list put port
//   rewind, rewind_tag                             : free-list rewind port
//   committed_front                                : committed front (visibility)
// Interface semantics: put/enable_put and rewind are single-cycle pulses
// with no back-pressure; they are registered and appear exactly one cycle
// after the qualifying group_commit&en / rewind_req&en. free_tag* and
// rewind_tag are only meaningful while their pulse is high and hold otherwise.
module commit_map_quad
  import fl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                group_commit,
  input  logic [WIDTH-1:0]    dest_valid,
  input  logic [4:0]          arch_dest0,
  input  logic [4:0]          arch_dest1,
  input  logic [4:0]          arch_dest2,
  input  logic [4:0]          arch_dest3,
  input  logic [TAG_BITS-1:0] phys_new0,
  input  logic [TAG_BITS-1:0] phys_new1,
  input  logic [TAG_BITS-1:0] phys_new2,
  input  logic [TAG_BITS-1:0] phys_new3,
  input  logic                rewind_req,
  output logic [WIDTH-1:0]    put,
  output logic                enable_put,
  output logic [TAG_BITS-1:0] free_tag0,
  output logic [TAG_BITS-1:0] free_tag1,
  output logic [TAG_BITS-1:0] free_tag2,
  output logic [TAG_BITS-1:0] free_tag3,
  output logic                rewind,
  output logic [TAG_BITS-1:0] rewind_tag,
  output logic [TAG_BITS-1:0] committed_front
);

  logic doCommit;
  logic doRewind;
  assign doCommit = en & group_commit;
  assign doRewind = en & rewind_req;

  phys_tag_t mapQ [N_ARCH];

  arch_reg_t [WIDTH-1:0] archVec;
  phys_tag_t [WIDTH-1:0] physVec;
  phys_tag_t [WIDTH-1:0] mapRead;
  phys_tag_t [WIDTH-1:0] selTag;

  assign archVec = {arch_dest3, arch_dest2, arch_dest1, arch_dest0};
  assign physVec = {phys_new3, phys_new2, phys_new1, phys_new0};

  for (genvar g = 0; g < WIDTH; g++) begin : gSlot
    assign mapRead[g] = mapQ[archVec[g]];
    free_tag_select #(.SLOT(g)) uSel (
      .destValid (dest_valid),
      .archDest  (archVec),
      .physNew   (physVec),
      .mapValue  (mapRead[g]),
      .freeTag   (selTag[g])
    );
  end

  // Front advance by one group, wrapped modulo the free-list depth.
  logic [TAG_BITS:0]   frontSum;
  logic [TAG_BITS-1:0] frontNext;
  logic [TAG_BITS-1:0] frontAfterCommit;

  always_comb begin
    frontSum = {1'b0, committed_front} + (TAG_BITS+1)'(WIDTH);
    if (frontSum >= (TAG_BITS+1)'(STACK_SIZE)) begin
      frontNext = TAG_BITS'(frontSum - (TAG_BITS+1)'(STACK_SIZE));
    end else begin
      frontNext = TAG_BITS'(frontSum);
    end
    // A rewind in the same cycle as a commit restores to the post-commit front.
    frontAfterCommit = doCommit ? frontNext : committed_front;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < N_ARCH; r++) begin
        mapQ[r] <= TAG_BITS'(r);
      end
      committed_front <= '0;
      put             <= '0;
      enable_put      <= 1'b0;
      free_tag0       <= '0;
      free_tag1       <= '0;
      free_tag2       <= '0;
      free_tag3       <= '0;
      rewind          <= 1'b0;
      rewind_tag      <= '0;
    end else begin
      put        <= doCommit ? {WIDTH{1'b1}} : '0;
      enable_put <= doCommit;
      rewind     <= doRewind;
      if (doCommit) begin
        free_tag0       <= selTag[0];
        free_tag1       <= selTag[1];
        free_tag2       <= selTag[2];
        free_tag3       <= selTag[3];
        committed_front <= frontNext;
        // Ascending slot order: the youngest writer of a register lands last.
        for (int i = 0; i < WIDTH; i++) begin
          if (dest_valid[i]) begin
            mapQ[archVec[i]] <= physVec[i];
          end
        end
      end
      if (doRewind) begin
        rewind_tag <= frontAfterCommit;
      end
    end
  end

endmodule

// File: tb/tb_commit_map_quad.sv
module tb_commit_map_quad;
  import fl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            en;
  logic            group_commit;
  logic [3:0]      dest_valid;
  logic [4:0]      in_arch [4];
  logic [5:0]      in_phys [4];
  logic            rewind_req;
  logic [3:0]      put;
  logic            enable_put;
  logic [5:0]      free_tag0, free_tag1, free_tag2, free_tag3;
  logic            rewind;
  logic [5:0]      rewind_tag;
  logic [5:0]      committed_front;

  commit_map_quad dut (
    .clk             (clk),
    .reset           (reset),
    .en              (en),
    .group_commit    (group_commit),
    .dest_valid      (dest_valid),
    .arch_dest0      (in_arch[0]),
    .arch_dest1      (in_arch[1]),
    .arch_dest2      (in_arch[2]),
    .arch_dest3      (in_arch[3]),
    .phys_new0       (in_phys[0]),
    .phys_new1       (in_phys[1]),
    .phys_new2       (in_phys[2]),
    .phys_new3       (in_phys[3]),
    .rewind_req      (rewind_req),
    .put             (put),
    .enable_put      (enable_put),
    .free_tag0       (free_tag0),
    .free_tag1       (free_tag1),
    .free_tag2       (free_tag2),
    .free_tag3       (free_tag3),
    .rewind          (rewind),
    .rewind_tag      (rewind_tag),
    .committed_front (committed_front)
  );

  // ---------------- scoreboard ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Commit is modelled as replaying the group's renames in program order on a
  // copy of the committed map: each writing slot frees the tag its register
  // held at that point, a non-writing slot gives its own take back.
  int m_map [32];
  int m_front;
  int m_free [4];
  int m_rtag;
  int m_put;
  int m_rewind;

  task automatic model_step(input bit rst_n, input bit e, input bit gc,
                            input logic [3:0] dv, input bit rw);
    int tmp [32];
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) m_map[r] = r;
      m_front = 0; m_rtag = 0; m_put = 0; m_rewind = 0;
      for (int i = 0; i < 4; i++) m_free[i] = 0;
    end else if (e) begin
      m_put = gc ? 15 : 0;
      m_rewind = rw ? 1 : 0;
      if (gc) begin
        tmp = m_map;
        for (int i = 0; i < 4; i++) begin
          if (dv[i]) begin
            m_free[i] = tmp[in_arch[i]];
            tmp[in_arch[i]] = int'(in_phys[i]);
          end else begin
            m_free[i] = int'(in_phys[i]);
          end
        end
        m_map = tmp;
        m_front = (m_front + 4) % 64;
      end
      if (rw) m_rtag = m_front;
    end else begin
      m_put = 0;
      m_rewind = 0;
    end
    exp_q.push_back(32'(m_put));
    exp_q.push_back(32'(m_put != 0));
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(m_free[i]));
    exp_q.push_back(32'(m_rewind));
    exp_q.push_back(32'(m_rtag));
    exp_q.push_back(32'(m_front));
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive, let the posedge sample, check at the next negedge.
  task automatic step(input bit rst_n, input bit e, input bit gc,
                      input logic [3:0] dv, input bit rw);
    reset = rst_n; en = e; group_commit = gc; dest_valid = dv; rewind_req = rw;
    model_step(rst_n, e, gc, dv, rw);
    @(posedge clk);
    @(negedge clk);
    check_val("put",             32'(put),             exp_q.pop_front());
    check_val("enable_put",      32'(enable_put),      exp_q.pop_front());
    check_val("free_tag0",       32'(free_tag0),       exp_q.pop_front());
    check_val("free_tag1",       32'(free_tag1),       exp_q.pop_front());
    check_val("free_tag2",       32'(free_tag2),       exp_q.pop_front());
    check_val("free_tag3",       32'(free_tag3),       exp_q.pop_front());
    check_val("rewind",          32'(rewind),          exp_q.pop_front());
    check_val("rewind_tag",      32'(rewind_tag),      exp_q.pop_front());
    check_val("committed_front", 32'(committed_front), exp_q.pop_front());
  endtask

  task automatic set_slots(input int a0, a1, a2, a3, input int p0, p1, p2, p3);
    in_arch[0] = 5'(a0); in_arch[1] = 5'(a1); in_arch[2] = 5'(a2); in_arch[3] = 5'(a3);
    in_phys[0] = 6'(p0); in_phys[1] = 6'(p1); in_phys[2] = 6'(p2); in_phys[3] = 6'(p3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; en = 1'b0; group_commit = 1'b0; dest_valid = '0; rewind_req = 1'b0;
    set_slots(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step(0, 1, 0, 4'b0000, 0);
    step(0, 1, 0, 4'b0000, 0);

    // Full group on distinct registers.
    set_slots(1, 2, 3, 4, 32, 33, 34, 35);
    step(1, 1, 1, 4'b1111, 0);
    check_val("t1_tag0_is_1", 32'(free_tag0), 32'd1);
    check_val("t1_front_4",   32'(committed_front), 32'd4);

    // Slots 0 and 2 write arch 5: slot 2 bypasses slot 0's new tag.
    set_slots(5, 9, 5, 11, 40, 41, 42, 43);
    step(1, 1, 1, 4'b0101, 0);
    check_val("t2_tag2_bypass", 32'(free_tag2), 32'd40);
    // map[5] must now be 42.
    set_slots(5, 0, 0, 0, 50, 51, 52, 53);
    step(1, 1, 1, 4'b0001, 0);
    check_val("t2_map5_42", 32'(free_tag0), 32'd42);

    // Back-to-back groups on arch 7.
    set_slots(7, 0, 0, 0, 36, 37, 38, 39);
    step(1, 1, 1, 4'b0001, 0);
    set_slots(7, 0, 0, 0, 44, 45, 46, 47);
    step(1, 1, 1, 4'b0001, 0);
    check_val("t3_frees_36", 32'(free_tag0), 32'd36);

    // Enable low with a commit: nothing happens, tags hold.
    set_slots(1, 2, 3, 4, 60, 61, 62, 63);
    step(1, 0, 1, 4'b1111, 1);
    step(1, 1, 0, 4'b0000, 0);

    // Sixteen commits from reset, rewind on the last one.
    step(0, 1, 0, 4'b0000, 0);
    for (int n = 0; n < 16; n++) begin
      set_slots(n % 32, (n + 1) % 32, (n + 2) % 32, (n + 3) % 32, n, n + 16, n + 32, n + 48);
      step(1, 1, 1, 4'b1111, n == 15);
    end
    check_val("t4_rewind_tag_0", 32'(rewind_tag), 32'd0);
    check_val("t4_rewind_1",     32'(rewind),     32'd1);

    // Reset asserted during a commit: reset wins, map back to identity.
    set_slots(3, 3, 3, 3, 20, 21, 22, 23);
    step(0, 1, 1, 4'b1111, 0);
    check_val("t6_put_0", 32'(put), 32'd0);
    set_slots(3, 8, 3, 30, 1, 2, 3, 4);
    step(1, 1, 1, 4'b1111, 0);
    check_val("t6_map3_ident", 32'(free_tag0), 32'd3);

    // Randomized traffic; narrow arch range part of the time to force bypasses.
    for (int n = 0; n < 400; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < 4; i++) begin
        in_arch[i] = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        in_phys[i] = 6'($urandom_range(0, 63));
      end
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
